// File: rtl/sfifo_flex.sv
// sfifo_flex: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable standard or first-word-fall-through read port.
module sfifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       wfull,
  output logic                       rempty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     data_cnt,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  // Handshake: a write is taken on a rising edge where winc=1 and the
  // registered wfull=0; a pop is taken where rinc=1 and the registered
  // rempty=0. A request against a blocking flag is dropped and reported by
  // a one-cycle overflow/underflow pulse. In standard mode rvalid marks the
  // single cycle holding a popped word; in FWFT mode rvalid marks that rdata
  // shows the head word, which rinc then consumes.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic [AW:0]      wptr_nxt, rptr_nxt, cnt_nxt;
  logic             wr_ok, rd_ok;

  // Accept decisions and next pointers; the wrap bit makes the pointer
  // difference an exact 0..DEPTH occupancy.
  always_comb begin
    wr_ok    = winc & ~wfull;
    rd_ok    = rinc & ~rempty;
    wptr_nxt = wr_ok ? wptr + PTR_ONE : wptr;
    rptr_nxt = rd_ok ? rptr + PTR_ONE : rptr;
    cnt_nxt  = wptr_nxt - rptr_nxt;
  end

  assign data_cnt = wptr - rptr;

  // Pointers, flags (from next occupancy, so they track data_cnt) and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      wfull        <= (cnt_nxt == DEPTH_C);
      rempty       <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      overflow     <= winc & wfull;
      underflow    <= rinc & rempty;
    end
  end

  // Storage array; not reset, writes ignored while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown combinationally; zero while empty.
      assign rdata  = rempty ? '0 : mem[rptr[AW-1:0]];
      assign rvalid = ~rempty;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;
      // Registered read: popped word appears one cycle after the pop.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_ok;
          if (rd_ok) rdata_q <= mem[rptr[AW-1:0]];
        end
      end
      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_flex.sv
// tb_sfifo_flex: drives a standard-mode FIFO (AF=12, AE=3) and an FWFT FIFO
// (default thresholds) with identical stimulus and compares both against a
// queue-based reference model.
module tb_sfifo_flex;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF0 = 12;
  localparam int AE0 = 3;
  localparam int AF1 = D - 2;
  localparam int AE1 = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         winc = 1'b0;
  logic         rinc = 1'b0;
  logic [W-1:0] wdata = '0;

  logic [W-1:0] rdata0, rdata1;
  logic         rvalid0, rvalid1, wfull0, wfull1, rempty0, rempty1;
  logic         af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [4:0]   cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];     // reference FIFO contents
  logic [W-1:0] exp_q[$];  // words expected on the standard-mode read port
  logic         e_ovf, e_unf, e_rv;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sfifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(AF0), .AE_LEVEL(AE0)) dut0 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
    .almost_full(af0), .almost_empty(ae0), .data_cnt(cnt0),
    .overflow(ovf0), .underflow(unf0));

  sfifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
    .almost_full(af1), .almost_empty(ae1), .data_cnt(cnt1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    int n;
    bit wr_ok, rd_ok;
    @(negedge clk);
    rst = r; winc = w; rinc = rd; wdata = d;
    if (r) begin
      mq.delete();
      e_ovf = 1'b0; e_unf = 1'b0; e_rv = 1'b0;
    end else begin
      wr_ok = w && (mq.size() < D);
      rd_ok = rd && (mq.size() > 0);
      e_ovf = w && (mq.size() == D);
      e_unf = rd && (mq.size() == 0);
      e_rv  = rd_ok;
      if (rd_ok) exp_q.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    n = mq.size();
    chk("data_cnt0", int'(cnt0), n);
    chk("data_cnt1", int'(cnt1), n);
    chk("wfull0", int'(wfull0), int'(n == D));
    chk("wfull1", int'(wfull1), int'(n == D));
    chk("rempty0", int'(rempty0), int'(n == 0));
    chk("rempty1", int'(rempty1), int'(n == 0));
    chk("almost_full0", int'(af0), int'(n >= AF0));
    chk("almost_full1", int'(af1), int'(n >= AF1));
    chk("almost_empty0", int'(ae0), int'(n <= AE0));
    chk("almost_empty1", int'(ae1), int'(n <= AE1));
    chk("overflow0", int'(ovf0), int'(e_ovf));
    chk("overflow1", int'(ovf1), int'(e_ovf));
    chk("underflow0", int'(unf0), int'(e_unf));
    chk("underflow1", int'(unf1), int'(e_unf));
    chk("rvalid0", int'(rvalid0), int'(e_rv));
    chk("rvalid1", int'(rvalid1), int'(n > 0));
    if (n > 0) chk("rdata1_head", int'(rdata1), int'(mq[0]));
    if (r) chk("rdata0_reset", int'(rdata0), 0);
  endtask

  // ---------------- scoreboard monitor (standard-mode read port) ----------------
  always @(negedge clk) begin
    if (rvalid0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata0_spurious: got %0d expected no valid word at %0t", rdata0, $time);
      end else begin
        chk("rdata0", int'(rdata0), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    e_ovf = 1'b0; e_unf = 1'b0; e_rv = 1'b0;
    // reset with both requests held high
    step(1, 1, 1, 8'hFF);
    step(1, 1, 1, 8'hFF);
    // fill past full, then drain past empty
    for (int i = 0; i < 17; i++) step(0, 1, 0, W'(i));
    for (int i = 0; i < 17; i++) step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    // simultaneous at full, then at empty
    for (int i = 0; i < 16; i++) step(0, 1, 0, W'(8'h40 + i));
    step(0, 1, 1, 8'hEE);
    for (int i = 0; i < 15; i++) step(0, 0, 1, '0);
    step(0, 1, 1, 8'hA5);
    // hold at 8 entries with streaming read+write across pointer wrap
    for (int i = 0; i < 7; i++) step(0, 1, 0, W'($urandom));
    for (int i = 0; i < 20; i++) step(0, 1, 1, W'($urandom));
    // randomized phases: fill-biased, drain-biased, balanced
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 200; i++) begin
        int wp, rp;
        wp = (p == 0) ? 80 : (p == 1) ? 20 : 50;
        rp = (p == 0) ? 20 : (p == 1) ? 80 : 50;
        step(($urandom_range(0, 99) < 1) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
             W'($urandom));
      end
    end
    // mid-fill reset
    for (int i = 0; i < 10; i++) step(0, 1, 0, W'($urandom));
    step(1, 1, 1, 8'h33);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfifo_flex.md
# sfifo_flex

Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It is the generic rate-decoupling buffer between same-clock producer and consumer stages.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).

Ports (AW = $clog2(DEPTH)). One clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- winc  in  1  write request.
- wdata  in  WIDTH  write data, sampled when a write is accepted.
- rinc  in  1  read request / pop.
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata holds a valid popped (FWFT=0) or head (FWFT=1) word.
- wfull  out  1  count == DEPTH.
- rempty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- data_cnt  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write attempted while full.
- underflow  out  1  one-cycle pulse: read attempted while empty.

## Operation
- Storage: DEPTH×WIDTH array, not reset. Write and read pointers are AW+1 bits (wrap bit + AW index); index wraps DEPTH-1 → 0 naturally.
- Accept rules, evaluated on current registered flags: wr_ok = winc & ~wfull; rd_ok = rinc & ~rempty.
- wr_ok: mem[wptr] ← wdata, wptr+1. rd_ok: rptr+1.
- Count: next = count + wr_ok − rd_ok; both → unchanged. Must never exceed DEPTH or go below 0.
- Flags wfull, rempty, almost_full, almost_empty are registered and computed from the next count, so they agree with data_cnt in the same cycle (no one-cycle lag).
- Full + winc + rinc: read accepted, write rejected, overflow pulses. Empty + winc + rinc: write accepted, read rejected, underflow pulses (in both modes).
- overflow/underflow: registered, high for exactly the cycle after the offending request; not sticky.
- FWFT=0: on rd_ok, rdata ← mem[rptr] registered; rvalid = 1 the following cycle only. Otherwise rdata holds its last value and rvalid = 0.
- FWFT=1: rdata = mem[rptr] (head word) whenever rempty = 0; rvalid = ~rempty. rinc acknowledges/pops the displayed word. rdata undefined when rempty = 1.
- Reset (any cycle, including mid-transfer): pointers, count, rdata → 0; rempty = 1, almost_empty = 1 (or 0 if AE_LEVEL < 0 is impossible, so always 1); wfull = 0; almost_full = 0 (AF_LEVEL ≥ 1); rvalid, overflow, underflow = 0. Requests in the reset cycle are ignored.

## Timing
- Write-to-flag: write accepted at edge N → data_cnt, rempty, almost flags updated after edge N.
- FWFT=0 read latency: rinc at edge N → rdata/rvalid valid after edge N (sampled at N+1).
- FWFT=1: first write into empty FIFO at edge N → rdata valid, rvalid = 1 after edge N.
- Full throughput: one write and one read per cycle sustained when neither flag blocks.
- Error pulses appear one cycle after the request edge.

## Test plan
- Reset: assert rst 2 cycles with winc=rinc=1 → data_cnt=0, rempty=1, almost_empty=1, wfull=0, rvalid=0, no pointer movement.
- Fill/drain (WIDTH=8, DEPTH=16, FWFT=0): write 0x00..0x0F → wfull=1 after 16th edge, almost_full=1 after 14th; 17th write → overflow pulse, data_cnt stays 16; read 16 → rdata 0x00..0x0F in order, rvalid each cycle after read, rempty=1 after last.
- Underflow: rinc on empty FIFO → underflow=1 for one cycle, rvalid=0, data_cnt=0.
- Simultaneous: at count=16 assert winc+rinc → count 15, overflow pulse; at count=0 assert both → count 1, underflow pulse; at count=8 both for 20 cycles → count stays 8, data order preserved across pointer wrap.
- FWFT=1: write 0xA5 into empty → rdata=0xA5, rvalid=1 the next cycle without rinc; rinc → rempty=1, rvalid=0.
- Thresholds (AF_LEVEL=12, AE_LEVEL=3): count 3 → almost_empty=1, 4 → 0; count 11 → almost_full=0, 12 → 1; then mid-fill rst → all outputs to reset values in one cycle.
